// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues in-order word-aligned imem requests,
// pairs each response with its PC and buffers the pairs in a DEPTH-entry
// output FIFO. A redirect flushes the FIFO and marks outstanding requests stale.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    // Occupancy counters hold 0..DEPTH (DEPTH <= 4); stale can accumulate
    // over back-to-back redirects, so it gets more headroom.
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 8;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [SW-1:0] stale_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ifq_pc_q    [DEPTH];
    logic [31:0] ifq_pc_d    [DEPTH];
    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] fifo_pc_d   [DEPTH];
    logic [31:0] fifo_inst_q [DEPTH];
    logic [31:0] fifo_inst_d [DEPTH];
    cnt_t        inflight_q, inflight_d;
    cnt_t        count_q, count_d;
    logic        valid_q, valid_d;
    stale_t      stale_q, stale_d;

    logic [31:0] target;
    logic        pop, credit, accept, rsp_live, rsp_stale;
    cnt_t        ifq_idx, fifo_idx;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request channel and per-cycle event decode
    always_comb begin
        target         = {redirect_pc[31:2], 2'b00};
        pop            = valid_q & out_ready & ~redirect_valid;
        credit         = (inflight_q + count_q - cnt_t'(pop)) < DEPTH_C;
        imem_req_valid = reset_n & credit;
        imem_req_addr  = redirect_valid ? target : fetch_pc_q;
        accept         = imem_req_valid & imem_req_ready;
        rsp_stale      = imem_rsp_valid & (stale_q != '0);
        rsp_live       = imem_rsp_valid & (stale_q == '0) & (inflight_q != '0);
    end

    // Next state for PC, in-flight PC queue, output FIFO and stale counter
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        ifq_pc_d    = ifq_pc_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        inflight_d  = inflight_q;
        count_d     = count_q;
        valid_d     = valid_q;
        stale_d     = stale_q;
        ifq_idx     = '0;
        fifo_idx    = '0;

        if (accept) begin
            fetch_pc_d = imem_req_addr + 32'd4;
        end else if (redirect_valid) begin
            fetch_pc_d = target;
        end

        if (redirect_valid) begin
            // Every request accepted before this cycle turns stale; a response
            // landing now retires one of them, whichever group it belongs to.
            stale_d = stale_q + stale_t'(inflight_q)
                    - stale_t'(imem_rsp_valid & ((stale_q != '0) | (inflight_q != '0)));
            inflight_d = cnt_t'(accept);
            if (accept) begin
                ifq_pc_d[0] = imem_req_addr;
            end
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            stale_d = stale_q - stale_t'(rsp_stale);

            // Both queues keep their head at index 0 so out_pc/out_inst are plain
            // register outputs; the push slot accounts for a same-cycle shift.
            if (rsp_live) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    ifq_pc_d[i] = ifq_pc_q[i+1];
                end
            end
            ifq_idx = inflight_q - cnt_t'(rsp_live);
            if (accept) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (cnt_t'(i) == ifq_idx) begin
                        ifq_pc_d[i] = imem_req_addr;
                    end
                end
            end
            inflight_d = inflight_q + cnt_t'(accept) - cnt_t'(rsp_live);

            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    fifo_pc_d[i]   = fifo_pc_q[i+1];
                    fifo_inst_d[i] = fifo_inst_q[i+1];
                end
            end
            fifo_idx = count_q - cnt_t'(pop);
            if (rsp_live) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (cnt_t'(i) == fifo_idx) begin
                        fifo_pc_d[i]   = ifq_pc_q[0];
                        fifo_inst_d[i] = imem_rsp_data;
                    end
                end
            end
            count_d = count_q + cnt_t'(rsp_live) - cnt_t'(pop);
            valid_d = (count_d != '0);
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ifq_pc_q[i]    <= '0;
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
            inflight_q <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            stale_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            ifq_pc_q    <= ifq_pc_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            stale_q     <= stale_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = fifo_pc_q[0];
    assign out_inst  = fifo_inst_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: in-order memory model with programmable latency, a scoreboard
// of expected {pc, inst} pairs, redirect vector table and reset sequences.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam int          DEPTH  = 2;

    logic        clock;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] mpc;
        int          due;
        int          ep;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] target;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    mem_t        mq[$];
    exp_t        sb[$];
    logic [31:0] popped[$];
    int          pop_cyc[$];
    int          checks;
    int          failures;
    int          cyc;
    int          lat;
    int          epoch;
    logic [31:0] model_fpc;
    logic        s_valid, s_reqv;
    logic [31:0] s_pc, s_addr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] get_pop(input int i);
        if (i < popped.size()) return popped[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int get_cyc(input int i);
        if (i < pop_cyc.size()) return pop_cyc[i];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, sample and check, advance model.
    task automatic step();
        mem_t        m;
        logic        have_rsp;
        logic        exp_valid, exp_credit, pop, acc;
        int          infl;
        logic [31:0] exp_addr;
        have_rsp       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        m              = '{addr: '0, mpc: '0, due: 0, ep: -1};
        if (mq.size() != 0 && mq[0].due == cyc) begin
            m              = mq.pop_front();
            have_rsp       = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(m.addr);
        end
        #1;
        s_valid = out_valid;
        s_pc    = out_pc;
        s_reqv  = imem_req_valid;
        s_addr  = imem_req_addr;

        exp_valid = (sb.size() != 0);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("out_pc", out_pc, sb[0].pc);
            chk("out_inst", out_inst, sb[0].inst);
        end
        pop  = exp_valid & out_ready & ~redirect_valid;
        infl = 0;
        foreach (mq[i]) if (mq[i].ep == epoch) infl++;
        if (have_rsp && m.ep == epoch) infl++;
        exp_credit = (infl + sb.size() - (pop ? 1 : 0)) < DEPTH;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_credit});
        exp_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : model_fpc;
        acc      = exp_credit & imem_req_ready;
        if (acc) chk("req_addr", imem_req_addr, exp_addr);

        if (pop) begin
            popped.push_back(out_pc);
            pop_cyc.push_back(cyc);
            void'(sb.pop_front());
        end
        if (redirect_valid) begin
            sb.delete();
            epoch++;
        end else if (have_rsp && m.ep == epoch) begin
            sb.push_back('{pc: m.mpc, inst: memfn(m.mpc)});
        end
        if (acc) begin
            m.addr = imem_req_addr;
            m.mpc  = exp_addr;
            m.due  = cyc + lat;
            if (mq.size() != 0 && m.due <= mq[$].due) m.due = mq[$].due + 1;
            m.ep   = epoch;
            mq.push_back(m);
            model_fpc = exp_addr + 32'd4;
        end else if (redirect_valid) begin
            model_fpc = exp_addr;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (popped.size() < n && k < limit) begin
            step();
            k++;
        end
        checks++;
        if (popped.size() < n) begin
            failures++;
            $display("FAIL %s: got %0d outputs expected %0d within %0d cycles", name, popped.size(), n, limit);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq.delete();
        sb.delete();
        epoch++;
        model_fpc = RST_PC;
        @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        reset_n = 1'b1;
        cyc     = 0;
        popped.delete();
        pop_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[5];
        int   base;
        vec[0] = '{lat: 3, target: 32'h0100_0100, exp0: 32'h0100_0100, exp1: 32'h0100_0104};
        vec[1] = '{lat: 1, target: 32'h0100_0102, exp0: 32'h0100_0100, exp1: 32'h0100_0104};
        vec[2] = '{lat: 1, target: 32'hFFFF_FFFC, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
        vec[3] = '{lat: 2, target: 32'h0000_0003, exp0: 32'h0000_0000, exp1: 32'h0000_0004};
        vec[4] = '{lat: 3, target: 32'h2000_0010, exp0: 32'h2000_0010, exp1: 32'h2000_0014};

        checks         = 0;
        failures       = 0;
        cyc            = 0;
        epoch          = 0;
        lat            = 1;
        model_fpc      = RST_PC;
        reset_n        = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Backpressure right after reset: head holds, requests stop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) chk("first_req_addr", s_addr, RST_PC);
            if (i >= 2) chk("bp_head_stable", s_pc, RST_PC);
            if (i == 4) chk("bp_req_valid_low", {31'b0, s_reqv}, 32'd0);
        end
        out_ready = 1'b1;
        run_until(4, 20, "bp_release_wait");
        for (int i = 0; i < 4; i++) begin
            chk("bp_release_seq", get_pop(i), RST_PC + 32'(4 * i));
        end

        // Mid-stream reset with a full FIFO
        out_ready = 1'b0;
        run(3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_pc", out_pc, 32'd0);
        chk("mid_rst_out_inst", out_inst, 32'd0);
        chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        do_reset();

        // Streaming throughput after release
        out_ready = 1'b1;
        step();
        chk("post_rst_first_addr", s_addr, RST_PC);
        run(4);
        for (int i = 0; i < 3; i++) begin
            chk("stream_pc", get_pop(i), RST_PC + 32'(4 * i));
            chk("stream_cycle", 32'(get_cyc(i)), 32'(2 + i));
        end

        // Redirect accepted in the same cycle it is raised
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        step();
        redirect_valid = 1'b0;
        chk("redir_accept_addr", s_addr, 32'h0000_4000);
        run_until(1, 10, "redir_accept_wait");
        chk("redir_accept_pc", get_pop(0), 32'h0000_4000);
        chk("redir_accept_latency", 32'(get_cyc(0)), 32'd2);

        // Redirect table while streaming, across memory latencies
        for (int t = 0; t < 5; t++) begin
            lat = vec[t].lat;
            run(6);
            base           = popped.size();
            redirect_valid = 1'b1;
            redirect_pc    = vec[t].target;
            step();
            redirect_valid = 1'b0;
            step();
            chk("redir_out_valid_low", {31'b0, s_valid}, 32'd0);
            run_until(base + 2, 30, "redir_wait");
            chk("redir_first_pc", get_pop(base), vec[t].exp0);
            chk("redir_second_pc", get_pop(base + 1), vec[t].exp1);
        end
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
